vc_fifo_elastic: RTL

VC_FIFO_ELASTIC -- requirements
Module: vc_fifo_elastic

---
 rtl/fabric_port_pkg.sv | 18 +
 rtl/vc_fifo_bank.sv | 73 +++++++
 rtl/vc_fifo_elastic.sv | 86 ++++++++
 3 files changed

// File: rtl/fabric_port_pkg.sv
// Shared sizing helpers and types for the VC fabric port.
// Used by the elastic VC FIFO and its per-channel bank.
package fabric_port_pkg;

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_NUM_VC = 2;
    localparam int DEFAULT_VC_W   = vc_width(DEFAULT_NUM_VC);

    typedef logic [DEFAULT_VC_W-1:0] vc_id_t;

endpackage

// File: rtl/vc_fifo_bank.sv
// One virtual channel: circular buffer with show-ahead head word.
// Status flags come straight from the registered occupancy count.
module vc_fifo_bank
    import fabric_port_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int DEPTH    = 4,
    parameter  int AF_LEVEL = 1,
    localparam int CW       = cnt_width(DEPTH),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] head,
    output logic             not_full,
    output logic             not_empty,
    output logic             almost_full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [31:0]      free_s;

    // Acceptance uses the pre-edge count, so a pop never frees room for a same-cycle write.
    always_comb begin
        wr_acc_s  = wr_req && (cnt_r != DEPTH_C);
        rd_acc_s  = rd_req && (cnt_r != {CW{1'b0}});
        cnt_nxt_s = cnt_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            cnt_r <= cnt_nxt_s;
        end
    end

    // Storage array, intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) mem_r[wr_ptr_r] <= wr_data;
    end

    // Status decode and show-ahead head word.
    always_comb begin
        free_s      = 32'(DEPTH) - 32'(cnt_r);
        not_full    = (cnt_r != DEPTH_C);
        not_empty   = (cnt_r != {CW{1'b0}});
        almost_full = (free_s <= 32'(AF_LEVEL));
        head        = mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/vc_fifo_elastic.sv
// Multi-VC elastic FIFO: write decode, read mux and error pulses around
// NUM_VC independent vc_fifo_bank instances.
module vc_fifo_elastic
    import fabric_port_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int DEPTH    = 4,
    parameter  int NUM_VC   = 2,
    parameter  int AF_LEVEL = 1,
    localparam int VC_W     = vc_width(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  i_data_in,
    input  logic [VC_W-1:0]   i_vc_in,
    input  logic              i_write_en,
    output logic [NUM_VC-1:0] i_ready_out,
    output logic [NUM_VC-1:0] i_almost_full,
    input  logic [VC_W-1:0]   o_read_vc,
    input  logic              o_read_en,
    output logic [WIDTH-1:0]  o_data_out,
    output logic [NUM_VC-1:0] o_ready_out,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [VC_W:0] NUM_VC_C = (VC_W + 1)'(NUM_VC);

    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic [NUM_VC-1:0] wr_sel_s;
    logic [NUM_VC-1:0] rd_sel_s;
    logic [WIDTH-1:0]  head_s [NUM_VC];
    logic              wr_drop_s;
    logic              rd_drop_s;
    logic              ovf_r;
    logic              udf_r;

    // Channel decode, AND-OR read mux and drop detection.
    always_comb begin
        wr_in_range_s = ({1'b0, i_vc_in} < NUM_VC_C);
        rd_in_range_s = ({1'b0, o_read_vc} < NUM_VC_C);
        o_data_out    = {WIDTH{1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel_s[v] = i_write_en && wr_in_range_s && (i_vc_in == VC_W'(v));
            rd_sel_s[v] = o_read_en && rd_in_range_s && (o_read_vc == VC_W'(v));
            o_data_out  = o_data_out |
                          ({WIDTH{rd_in_range_s && (o_read_vc == VC_W'(v))}} & head_s[v]);
        end
        wr_drop_s = i_write_en && !(|(wr_sel_s & i_ready_out));
        rd_drop_s = o_read_en && !(|(rd_sel_s & o_ready_out));
    end

    // One-cycle error pulses for dropped writes and ignored reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= wr_drop_s;
            udf_r <= rd_drop_s;
        end
    end

    assign o_overflow  = ovf_r;
    assign o_underflow = udf_r;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_bank
        vc_fifo_bank #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_req      (wr_sel_s[g]),
            .wr_data     (i_data_in),
            .rd_req      (rd_sel_s[g]),
            .head        (head_s[g]),
            .not_full    (i_ready_out[g]),
            .not_empty   (o_ready_out[g]),
            .almost_full (i_almost_full[g])
        );
    end

endmodule
